// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 01010101 preamble transmitter and its detector
// benches.
//   state_t       : transmitter FSM encoding (IDLE, PRE, DATA)
//   PRE_PAT_DEF   : default preamble, sent MSB first -> 0,1,0,1,0,1,0,1
//   IDLE_LVL_DEF  : default line level between frames; a 1 never advances
//                   the detector out of its initial state
//   cnt_width()   : bit counter width, clog2(max(a,b)) with a floor of 1
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [7:0] PRE_PAT_DEF  = 8'h55;
    localparam logic       IDLE_LVL_DEF = 1'b1;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// ---------------------------------------------------------------------------
// piso_shreg
// Parallel-load, MSB-first shift register.
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset, clears the register
//   load     : capture pdata on this edge (has priority over shift)
//   shift    : move contents one place towards the MSB, zero fill
//   pdata    : parallel load value
//   msb_next : the MSB the register will hold after this edge
//
// msb_next lets the owner register its serial output in the same cycle as
// the register update, so the serial bit appears on the cycle right after a
// load without an extra pipeline stage.
// ---------------------------------------------------------------------------
module piso_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] pdata,
    output logic         msb_next
);

    logic [W-1:0] q;
    logic [W-1:0] q_shifted;
    logic [W-1:0] q_next;

    // Written as a shift by one so W=1 needs no special case.
    assign q_shifted = q << 1;

    always_comb begin
        q_next = q;
        if (load) begin
            q_next = pdata;
        end else if (shift) begin
            q_next = q_shifted;
        end
    end

    assign msb_next = q_next[W-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/preamble_tx.sv
// ---------------------------------------------------------------------------
// preamble_tx
// Serial frame transmitter: on an accepted start it sends PRE_LEN preamble
// bits (PRE_PAT, MSB first) followed by DATA_W payload bits (MSB first),
// one bit per clock.
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset, the only reset
//   start      : frame request, accepted when start=1 and ready=1
//   din        : payload, captured on the accepting edge only
//   ready      : high while idle
//   dout       : serial line, IDLE_LVL between frames
//   dout_valid : high while dout carries a preamble or payload bit
//   sof        : one-cycle pulse with the first preamble bit
//   done       : one-cycle pulse with the last payload bit
//   dbg_state  : current FSM state, for observation only
//
// Handshake: a frame is accepted on a rising edge where start=1 and ready=1;
// start is ignored (not queued) whenever ready=0, and din is not looked at
// after the accepting edge.
//
// Every output is a flop. The output decode runs on the next state and the
// next shift-register MSBs, so the output flops change on the same edge as
// the FSM and the first preamble bit appears in the cycle after acceptance.
// ---------------------------------------------------------------------------
module preamble_tx
    import seq_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter int                 PRE_LEN  = 8,
    parameter logic [PRE_LEN-1:0] PRE_PAT  = PRE_LEN'(PRE_PAT_DEF),
    parameter logic               IDLE_LVL = IDLE_LVL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              sof,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int                CNT_W     = cnt_width(PRE_LEN, DATA_W);
    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;

    logic               load;
    logic               pat_shift;
    logic               data_shift;
    logic               pat_msb_next;
    logic               data_msb_next;

    logic               dout_d;
    logic               valid_d;
    logic               sof_d;
    logic               done_d;
    logic               ready_d;

    // -----------------------------------------------------------------------
    // Shift registers: preamble pattern and payload
    // -----------------------------------------------------------------------
    piso_shreg #(
        .W (PRE_LEN)
    ) u_pat_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (pat_shift),
        .pdata    (PRE_PAT),
        .msb_next (pat_msb_next)
    );

    piso_shreg #(
        .W (DATA_W)
    ) u_data_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (data_shift),
        .pdata    (din),
        .msb_next (data_msb_next)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // The counter is reset to 0 on every state change and only increments
    // below the terminal count of the current phase, so it never wraps.
    // -----------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        load       = 1'b0;
        pat_shift  = 1'b0;
        data_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_PRE;
                    cnt_n   = '0;
                    load    = 1'b1;
                end
            end
            ST_PRE: begin
                pat_shift = 1'b1;
                if (cnt == PRE_LAST) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                data_shift = 1'b1;
                if (cnt == DATA_LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                // Unused encoding: recover to idle on the next edge.
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode, evaluated for the cycle after the coming edge
    // -----------------------------------------------------------------------
    always_comb begin
        dout_d  = IDLE_LVL;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
        case (state_n)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_PRE: begin
                dout_d  = pat_msb_next;
                valid_d = 1'b1;
                sof_d   = (cnt_n == '0);
            end
            ST_DATA: begin
                dout_d  = data_msb_next;
                valid_d = 1'b1;
                done_d  = (cnt_n == DATA_LAST);
            end
            default: begin
                ready_d = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout       <= IDLE_LVL;
            dout_valid <= 1'b0;
            sof        <= 1'b0;
            done       <= 1'b0;
            ready      <= 1'b1;
        end else begin
            dout       <= dout_d;
            dout_valid <= valid_d;
            sof        <= sof_d;
            done       <= done_d;
            ready      <= ready_d;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_preamble_tx.sv
// ---------------------------------------------------------------------------
// tb_preamble_tx
// Directed and random stimulus for preamble_tx with default parameters.
// Reference model: a queue of expected {dout, dout_valid, sof, done} words.
// An accepted start appends the 16 words of a whole frame; each clock pops
// one; an empty queue means idle (dout=1, ready=1). A bench-side stand-in
// for the 01010101 detector watches dout for the loopback step.
// ---------------------------------------------------------------------------
module tb_preamble_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       ready;
    logic       dout;
    logic       dout_valid;
    logic       sof;
    logic       done;
    logic [1:0] dbg_state;

    int         tests;
    int         fails;

    logic [3:0] exp_q[$];     // {dout, dout_valid, sof, done}
    logic [7:0] hist;         // last 8 dout bits, newest in bit 0
    logic       det_flag;     // detector flag for the current cycle

    preamble_tx dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .ready      (ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sof        (sof),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // A frame as seen on the line: preamble 0,1,0,1,0,1,0,1 then payload MSB first.
    task automatic push_frame(input logic [7:0] d);
        logic [7:0] pre;
        logic       b;
        pre = 8'h55;
        for (int i = 0; i < 16; i++) begin
            b = (i < 8) ? pre[7 - i] : d[15 - i];
            exp_q.push_back({b, 1'b1, (i == 0), (i == 15)});
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model with the
    // inputs present this cycle, then move to just after the next rising edge.
    task automatic tick();
        logic [3:0] e;
        logic       e_ready;
        logic       was_idle;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e       = exp_q[0];
            e_ready = 1'b0;
        end else begin
            e       = 4'b1000;
            e_ready = 1'b1;
        end
        check("dout",       dout,       e[3]);
        check("dout_valid", dout_valid, e[2]);
        check("sof",        sof,        e[1]);
        check("done",       done,       e[0]);
        check("ready",      ready,      e_ready);
        check("state_legal", (dbg_state != 2'd3), 1'b1);

        hist     = {hist[6:0], dout};
        det_flag = (hist == 8'h55);

        if (!rst) begin
            exp_q.delete();
        end else begin
            was_idle = (exp_q.size() == 0);
            if (!was_idle) begin
                void'(exp_q.pop_front());
            end
            if (was_idle && start) begin
                push_frame(din);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tests    = 0;
        fails    = 0;
        hist     = 8'hFF;
        det_flag = 1'b0;

        // Reset held two cycles with start asserted: reset wins.
        rst   = 1'b0;
        start = 1'b1;
        din   = 8'hA3;
        tick();
        tick();

        // Released, no start: stays idle.
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();

        // Single frame 8'hA3, with a busy start of 8'hFF at T+5.
        din   = 8'hA3;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 18; k++) begin
            start = (k == 5);
            din   = (k == 5) ? 8'hFF : 8'($urandom);
            tick();
        end

        // Back-to-back: start held high, 8'h0F then 8'hF0.
        start = 1'b1;
        din   = 8'h0F;
        tick();
        din = 8'hF0;
        for (int k = 1; k <= 17; k++) begin
            tick();
        end
        start = 1'b0;
        din   = 8'h00;
        for (int k = 0; k < 18; k++) begin
            tick();
        end

        // Mid-frame reset at T+10, then a fresh frame.
        start = 1'b1;
        din   = 8'h5C;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
        end
        start = 1'b1;
        din   = 8'h96;
        tick();
        start = 1'b0;
        for (int k = 0; k < 18; k++) begin
            tick();
        end

        // Loopback: payload 8'h00, detector flag exactly in T+9.
        start = 1'b1;
        din   = 8'h00;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            check("det_flag", det_flag, (k == 9));
            tick();
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 3) == 0);
            din   = 8'($urandom);
            rst   = ($urandom_range(0, 79) != 0);
            tick();
        end
        rst   = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
